// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : In-order fetch-to-decode FIFO with PC_write back-pressure and
//            branch flush. Optional stats counters under FETCH_QUEUE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_IF,
  input  logic [31:0] INSTRUCTION_IF,
  input  logic        PCSrc,
  output logic        PC_write,
  input  logic        ID_ready,
  output logic        valid_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] INSTRUCTION_ID
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0] flush_count,
  output logic [15:0] stall_count
`endif
);

  localparam int               c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]    c_full    = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw-1:0]  c_ptr_one = (c_aw)'(1);
  localparam logic [c_aw:0]    c_cnt_one = (c_aw + 1)'(1);

  logic [31:0]     r_pc_mem    [DEPTH];
  logic [31:0]     r_instr_mem [DEPTH];
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);

  // A full queue never enqueues, even on a same-cycle dequeue, so PC_write
  // stays a function of registered state and PCSrc only.
  assign w_enq    = !w_full && !PCSrc;
  assign w_deq    = valid_ID && ID_ready && !PCSrc;
  assign PC_write = !w_full || PCSrc;

  always_ff @(posedge clk) begin
    if (reset || PCSrc) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_deq) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_enq && !w_deq)
        r_count <= r_count + c_cnt_one;
      else if (!w_enq && w_deq)
        r_count <= r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_enq) begin
      r_pc_mem[r_wr_ptr]    <= PC_IF;
      r_instr_mem[r_wr_ptr] <= INSTRUCTION_IF;
    end
  end

  assign valid_ID       = !w_empty;
  assign PC_ID          = valid_ID ? r_pc_mem[r_rd_ptr]    : 32'h0;
  assign INSTRUCTION_ID = valid_ID ? r_instr_mem[r_rd_ptr] : NOP_INSTR;

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] r_flush_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (PCSrc && r_flush_count != 16'hFFFF)
        r_flush_count <= r_flush_count + 16'd1;
      if (w_full && !PCSrc && r_stall_count != 16'hFFFF)
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign flush_count = r_flush_count;
  assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed self-checking bench for fetch_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_IF;
  logic [31:0] INSTRUCTION_IF;
  logic        PCSrc;
  logic        PC_write;
  logic        ID_ready;
  logic        valid_ID;
  logic [31:0] PC_ID;
  logic [31:0] INSTRUCTION_ID;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] flush_count;
  logic [15:0] stall_count;
`endif

  int          passed = 0;
  int          total  = 0;
  logic [31:0] pc     = 32'h0;
  logic [31:0] target = 32'h200;

  fetch_queue #(.DEPTH(4), .NOP_INSTR(c_nop)) dut (
    .clk            (clk),
    .reset          (reset),
    .PC_IF          (PC_IF),
    .INSTRUCTION_IF (INSTRUCTION_IF),
    .PCSrc          (PCSrc),
    .PC_write       (PC_write),
    .ID_ready       (ID_ready),
    .valid_ID       (valid_ID),
    .PC_ID          (PC_ID),
    .INSTRUCTION_ID (INSTRUCTION_ID)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .flush_count    (flush_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Behaves as the fetch stage: PC advances on PC_write, redirects on PCSrc.
  task automatic tick();
    logic pw, br, rs;
    pw = PC_write;
    br = PCSrc;
    rs = reset;
    @(posedge clk);
    #1;
    if (rs)      pc = 32'h0;
    else if (br) pc = target;
    else if (pw) pc = pc + 32'd4;
    PC_IF          = pc;
    INSTRUCTION_IF = pc + 32'h100;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    PCSrc = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    PCSrc          = 1'b0;
    ID_ready       = 1'b0;
    PC_IF          = 32'h0;
    INSTRUCTION_IF = 32'h100;

    // Reset then idle
    do_reset();
    chk("rst_valid", {31'b0, valid_ID}, 32'd0);
    chk("rst_pc",    PC_ID,             32'h0);
    chk("rst_instr", INSTRUCTION_ID,    c_nop);
    chk("rst_pcw",   {31'b0, PC_write}, 32'd1);
`ifdef FETCH_QUEUE_STATS_EN
    chk("rst_flushcnt", {16'b0, flush_count}, 32'd0);
    chk("rst_stallcnt", {16'b0, stall_count}, 32'd0);
`endif

    // Streaming with decode always ready
    ID_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stream_pc",    PC_ID,             32'(4 * k));
      chk("stream_instr", INSTRUCTION_ID,    32'(4 * k) + 32'h100);
      chk("stream_valid", {31'b0, valid_ID}, 32'd1);
      chk("stream_pcw",   {31'b0, PC_write}, 32'd1);
    end

    // Back-pressure: decode stalls for 6 cycles
    do_reset();
    ID_ready = 1'b0;
    tick(); tick(); tick();
    chk("bp_pcw_3", {31'b0, PC_write}, 32'd1);
    chk("bp_head_3", PC_ID, 32'h0);
    tick();
    chk("bp_pcw_4", {31'b0, PC_write}, 32'd0);
    tick(); tick();
    chk("bp_pcw_6",  {31'b0, PC_write}, 32'd0);
    chk("bp_head_6", PC_ID,             32'h0);
    chk("bp_fetch_held", PC_IF,         32'd16);
`ifdef FETCH_QUEUE_STATS_EN
    chk("bp_stallcnt", {16'b0, stall_count}, 32'd2);
`endif
    ID_ready = 1'b1;
    #1;
    chk("bp_pcw_no_ready_path", {31'b0, PC_write}, 32'd0);
    tick();
    chk("bp_drain_4",   PC_ID,             32'd4);
    chk("bp_pcw_back",  {31'b0, PC_write}, 32'd1);
    tick();
    chk("bp_drain_8",   PC_ID,             32'd8);
    tick();
    chk("bp_drain_12",  PC_ID,             32'd12);
    chk("bp_drain_i12", INSTRUCTION_ID,    32'd12 + 32'h100);
    tick();
    chk("bp_drain_16",  PC_ID,             32'd16);

    // Flush while full
    do_reset();
    ID_ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk("fl_full_pcw", {31'b0, PC_write}, 32'd0);
    PCSrc = 1'b1;
    #1;
    chk("fl_pcw_forced", {31'b0, PC_write}, 32'd1);
    tick();
    PCSrc = 1'b0;
    #1;
    chk("fl_valid",  {31'b0, valid_ID}, 32'd0);
    chk("fl_pc",     PC_ID,             32'h0);
    chk("fl_instr",  INSTRUCTION_ID,    c_nop);
    chk("fl_pcw",    {31'b0, PC_write}, 32'd1);
    chk("fl_target", PC_IF,             32'h200);
`ifdef FETCH_QUEUE_STATS_EN
    chk("fl_flushcnt", {16'b0, flush_count}, 32'd1);
`endif
    tick();
    chk("fl_first_valid", {31'b0, valid_ID}, 32'd1);
    chk("fl_first_pc",    PC_ID,             32'h200);
    chk("fl_first_instr", INSTRUCTION_ID,    32'h300);

    // Hold two entries while streaming across pointer wrap
    tick();
    chk("wr_head_hold", PC_ID, 32'h200);
    ID_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("wrap_pc",    PC_ID,          32'h200 + 32'(4 * k));
      chk("wrap_instr", INSTRUCTION_ID, 32'h300 + 32'(4 * k));
      chk("wrap_valid", {31'b0, valid_ID}, 32'd1);
    end

    // Reset together with a flush in mid-operation
    do_reset();
    ID_ready = 1'b0;
    tick(); tick(); tick();
    chk("mr_pre_valid", {31'b0, valid_ID}, 32'd1);
    reset = 1'b1;
    PCSrc = 1'b1;
    tick();
    reset = 1'b0;
    PCSrc = 1'b0;
    #1;
    chk("mr_valid", {31'b0, valid_ID}, 32'd0);
    chk("mr_pc",    PC_ID,             32'h0);
    chk("mr_instr", INSTRUCTION_ID,    c_nop);
    chk("mr_pcw",   {31'b0, PC_write}, 32'd1);
`ifdef FETCH_QUEUE_STATS_EN
    chk("mr_flushcnt", {16'b0, flush_count}, 32'd0);
    chk("mr_stallcnt", {16'b0, stall_count}, 32'd0);
`endif
    tick();
    chk("mr_restart_pc",    PC_ID,             32'h0);
    chk("mr_restart_valid", {31'b0, valid_ID}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
